// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker on the controller's 6-bit light vector (phase order, dwell, legality).
// Optional macro TRAFFIC_MON_CAPTURE_EN adds first-error code/pattern capture outputs.
module traffic_monitor #(
  parameter int GREEN_T  = 45,
  parameter int YELLOW_T = 15,
  parameter int TOL      = 1,
  parameter int CW       = 16
) (
  input  logic          clk100mhz,
  input  logic          clr_n,
  input  logic          tick,
  input  logic [5:0]    lights,
  input  logic          err_clr,
  output logic [1:0]    phase,
  output logic          locked,
  output logic [7:0]    dwell,
  output logic [CW-1:0] cycle_cnt,
  output logic          err_illegal,
  output logic          err_order,
  output logic          err_time,
  output logic          err_pulse
`ifdef TRAFFIC_MON_CAPTURE_EN
  ,
  output logic [1:0]    first_err_code,
  output logic [5:0]    first_err_lights
`endif
);

  localparam logic [5:0] P0 = 6'b001100;
  localparam logic [5:0] P1 = 6'b010100;
  localparam logic [5:0] P2 = 6'b100001;
  localparam logic [5:0] P3 = 6'b100010;

  localparam logic [0:0] S_SYNC  = 1'b0;
  localparam logic [0:0] S_TRACK = 1'b1;

  logic [0:0]    r_state;
  logic [5:0]    r_prevLights;
  logic [1:0]    r_phase;
  logic [7:0]    r_dwell;
  logic          r_locked;
  logic          r_first;
  logic [CW-1:0] r_cycleCnt;
  logic          r_errIll;
  logic          r_errOrd;
  logic          r_errTime;
  logic          r_errPulse;

  logic          w_legal;
  logic [1:0]    w_newPhase;
  logic [1:0]    w_nextPhase;
  logic          w_change;
  logic          w_succ;
  logic          w_dwellInc;
  logic          w_newIll;
  logic          w_newOrd;
  logic          w_newTime;
  logic          w_newErr;
  int            w_expT;

  always_comb begin
    w_legal    = 1'b1;
    w_newPhase = 2'd0;
    case (lights)
      P0:      w_newPhase = 2'd0;
      P1:      w_newPhase = 2'd1;
      P2:      w_newPhase = 2'd2;
      P3:      w_newPhase = 2'd3;
      default: w_legal    = 1'b0;
    endcase
  end

  assign w_nextPhase = r_phase + 2'd1;
  assign w_change    = (lights != r_prevLights);
  assign w_succ      = w_legal && (w_newPhase == w_nextPhase);
  assign w_expT      = r_phase[0] ? YELLOW_T : GREEN_T;

  // A tick arriving on the same edge as a pattern change is dropped on purpose.
  always_comb begin
    w_dwellInc = 1'b0;
    w_newIll   = 1'b0;
    w_newOrd   = 1'b0;
    w_newTime  = 1'b0;
    if (r_state == S_TRACK) begin
      if (!w_change) begin
        w_dwellInc = tick && (r_dwell != 8'hFF);
        w_newTime  = w_dwellInc && (int'(r_dwell) == w_expT + TOL);
      end else if (!w_legal) begin
        w_newIll = 1'b1;
      end else if (!w_succ) begin
        w_newOrd = 1'b1;
      end else begin
        w_newTime = !r_first && (int'(r_dwell) < w_expT - TOL);
      end
    end
  end

  assign w_newErr = w_newIll | w_newOrd | w_newTime;

  always_ff @(posedge clk100mhz or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= S_SYNC;
      r_prevLights <= 6'd0;
      r_phase      <= 2'd0;
      r_dwell      <= 8'd0;
      r_locked     <= 1'b0;
      r_first      <= 1'b0;
      r_cycleCnt   <= '0;
    end else begin
      r_prevLights <= lights;
      if (r_state == S_SYNC) begin
        if (w_legal) begin
          r_phase  <= w_newPhase;
          r_dwell  <= 8'd0;
          r_locked <= 1'b1;
          r_first  <= 1'b1;
          r_state  <= S_TRACK;
        end
      end else if (!w_change) begin
        if (w_dwellInc) r_dwell <= r_dwell + 8'd1;
      end else if (!w_legal) begin
        r_locked <= 1'b0;
        r_state  <= S_SYNC;
      end else if (!w_succ) begin
        r_phase <= w_newPhase;
        r_dwell <= 8'd0;
        r_first <= 1'b1;
      end else begin
        r_phase <= w_nextPhase;
        r_dwell <= 8'd0;
        r_first <= 1'b0;
        if (r_phase == 2'd3) r_cycleCnt <= r_cycleCnt + CW'(1);
      end
    end
  end

  // A clear and a fresh error on the same edge leave the fresh flag set.
  always_ff @(posedge clk100mhz or negedge clr_n) begin
    if (!clr_n) begin
      r_errIll   <= 1'b0;
      r_errOrd   <= 1'b0;
      r_errTime  <= 1'b0;
      r_errPulse <= 1'b0;
    end else begin
      r_errIll   <= (r_errIll  & ~err_clr) | w_newIll;
      r_errOrd   <= (r_errOrd  & ~err_clr) | w_newOrd;
      r_errTime  <= (r_errTime & ~err_clr) | w_newTime;
      r_errPulse <= w_newErr;
    end
  end

  assign phase       = r_phase;
  assign locked      = r_locked;
  assign dwell       = r_dwell;
  assign cycle_cnt   = r_cycleCnt;
  assign err_illegal = r_errIll;
  assign err_order   = r_errOrd;
  assign err_time    = r_errTime;
  assign err_pulse   = r_errPulse;

`ifdef TRAFFIC_MON_CAPTURE_EN
  logic       r_capValid;
  logic [1:0] r_capCode;
  logic [5:0] r_capLights;
  logic [1:0] w_errCode;

  assign w_errCode = w_newIll ? 2'd1 : (w_newOrd ? 2'd2 : 2'd3);

  always_ff @(posedge clk100mhz or negedge clr_n) begin
    if (!clr_n) begin
      r_capValid  <= 1'b0;
      r_capCode   <= 2'd0;
      r_capLights <= 6'd0;
    end else if (err_clr) begin
      r_capValid  <= w_newErr;
      r_capCode   <= w_newErr ? w_errCode : 2'd0;
      r_capLights <= w_newErr ? lights : 6'd0;
    end else if (w_newErr && !r_capValid) begin
      r_capValid  <= 1'b1;
      r_capCode   <= w_errCode;
      r_capLights <= lights;
    end
  end

  assign first_err_code   = r_capCode;
  assign first_err_lights = r_capLights;
`endif

endmodule
